thunderbird_turn_input: RTL and testbench



---
 rtl/thunderbird_turn_input.sv | 95 +++++++++
 tb/tb_thunderbird_turn_input.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/thunderbird_turn_input.sv
// Turn-lever / hazard input conditioner for the tail-light sequencer.
// Each raw contact is synchronized and debounced; the hazard press becomes a latched toggle.
module thunderbird_turn_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic Clk,
  input  logic reset,
  input  logic lever_left,
  input  logic lever_right,
  input  logic hazard_btn,
  output logic left,
  output logic right,
  output logic hazard_active,
  output logic lever_fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = left lever, 1 = right lever, 2 = hazard button.
  logic [2:0] raw_in;
  logic [2:0] deb;

  assign raw_in = {hazard_btn, lever_right, lever_left};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic             s1_q, s1_d;
      logic             s2_q, s2_d;
      logic             deb_q, deb_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d  = raw_in[gi];
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = '0;
        // Any return to the debounced level leaves cnt_d at 0, restarting the count.
        if (s2_q != deb_q) begin
          if (cnt_q == CNT_MAX) begin
            deb_d = s2_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge Clk) begin
        if (reset) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          deb_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= s1_d;
          s2_q  <= s2_d;
          deb_q <= deb_d;
          cnt_q <= cnt_d;
        end
      end

      assign deb[gi] = deb_q;
    end
  endgenerate

  logic deb_l, deb_r, deb_h;
  logic deb_h_dly_q, deb_h_dly_d;
  logic hazard_active_q, hazard_active_d;

  assign deb_l = deb[0];
  assign deb_r = deb[1];
  assign deb_h = deb[2];

  // Rising edge of the debounced button toggles the latch once per press.
  always_comb begin
    deb_h_dly_d     = deb_h;
    hazard_active_d = hazard_active_q ^ (deb_h & ~deb_h_dly_q);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      deb_h_dly_q     <= 1'b0;
      hazard_active_q <= 1'b0;
    end else begin
      deb_h_dly_q     <= deb_h_dly_d;
      hazard_active_q <= hazard_active_d;
    end
  end

  assign hazard_active = hazard_active_q;
  assign lever_fault   = deb_l & deb_r;
  assign left          = hazard_active_q | (deb_l & ~deb_r);
  assign right         = hazard_active_q | (deb_r & ~deb_l);

endmodule

// File: tb/tb_thunderbird_turn_input.sv
// Directed bench for thunderbird_turn_input with DEBOUNCE_CYCLES = 4.
// Table rows hold inputs for N cycles then compare {left,right,hazard_active,lever_fault}.
module tb_thunderbird_turn_input;

  logic Clk = 1'b0;
  logic reset;
  logic lever_left, lever_right, hazard_btn;
  logic left, right, hazard_active, lever_fault;

  int total = 0;
  int bad   = 0;

  thunderbird_turn_input #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .lever_left   (lever_left),
    .lever_right  (lever_right),
    .hazard_btn   (hazard_btn),
    .left         (left),
    .right        (right),
    .hazard_active(hazard_active),
    .lever_fault  (lever_fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       ll;
    logic       lr;
    logic       hz;
    int         hold;
    logic [3:0] exp;   // {left, right, hazard_active, lever_fault}
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] outs();
    return {left, right, hazard_active, lever_fault};
  endfunction

  // One clock edge, then settle half a cycle before sampling or driving.
  task automatic tick();
    @(posedge Clk);
    #5;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got lrhf=%b expected %b at %0t", name, got, exp, $time);
    end else begin
      $display("ok   %s: lrhf=%b at %0t", name, got, $time);
    end
  endtask

  function automatic void add(input logic ll, input logic lr, input logic hz,
                              input int hold, input logic [3:0] exp, input string name);
    vec_t v;
    v.ll = ll; v.lr = lr; v.hz = hz; v.hold = hold; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; lever_left = 1'b0; lever_right = 1'b0; hazard_btn = 1'b0;

    // Clean left lever: flips on the 6th edge after the change.
    add(0, 0, 0, 20, 4'b0000, "idle_20");
    add(1, 0, 0, 5,  4'b0000, "left_before_e5");
    add(1, 0, 0, 1,  4'b1000, "left_at_e5");
    add(0, 0, 0, 5,  4'b1000, "left_drop_before");
    add(0, 0, 0, 1,  4'b0000, "left_drop_at_e5");
    // Hazard toggle at the 7th edge, holding and releasing do nothing.
    add(0, 0, 1, 6,  4'b0000, "haz_before_e6");
    add(0, 0, 1, 1,  4'b1110, "haz_at_e6");
    add(0, 0, 1, 23, 4'b1110, "haz_held");
    add(0, 0, 0, 10, 4'b1110, "haz_released");
    add(0, 0, 1, 6,  4'b1110, "haz2_before_e6");
    add(0, 0, 1, 1,  4'b0000, "haz2_at_e6");
    add(0, 0, 0, 10, 4'b0000, "haz2_released");
    // Hazard overrides lever; cancelling exposes the lever.
    add(0, 0, 1, 7,  4'b1110, "haz3_on");
    add(0, 0, 0, 10, 4'b1110, "haz3_released");
    add(1, 0, 0, 10, 4'b1110, "haz_over_left");
    add(1, 0, 1, 6,  4'b1110, "cancel_before_e6");
    add(1, 0, 1, 1,  4'b1000, "cancel_at_e6");
    add(1, 0, 0, 10, 4'b1000, "left_after_cancel");
    // Both levers: fault blanks left/right unless hazard is on.
    add(1, 1, 0, 5,  4'b1000, "fault_before");
    add(1, 1, 0, 1,  4'b0001, "fault_set");
    add(1, 1, 1, 7,  4'b1111, "fault_with_haz");
    add(1, 1, 0, 10, 4'b1111, "fault_haz_released");
    add(1, 1, 1, 7,  4'b0001, "fault_haz_cancel");
    add(0, 0, 0, 10, 4'b0000, "all_idle");

    tick();
    check("reset_edge1", outs(), 4'b0000);
    tick();
    check("reset_edge2", outs(), 4'b0000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      lever_left = vecs[i].ll; lever_right = vecs[i].lr; hazard_btn = vecs[i].hz;
      for (int c = 0; c < vecs[i].hold; c++) tick();
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // Bounce on the right lever: 2-cycle pulses never reach the threshold.
    for (int b = 0; b < 4; b++) begin
      lever_right = (b % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        tick();
        check("bounce_right_low", outs(), 4'b0000);
      end
    end
    lever_right = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("bounce_settle_e%0d", c - 1), outs(), (c == 6) ? 4'b0100 : 4'b0000);
    end
    lever_right = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check("right_released", outs(), 4'b0000);

    // A 3-cycle glitch must never reach the output.
    lever_right = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    lever_right = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("glitch3_right", outs(), 4'b0000);
    end

    // Reset while both levers stay high, then recover after 6 edges.
    lever_left = 1'b1; lever_right = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("fault_before_reset", outs(), 4'b0001);
    reset = 1'b1;
    tick();
    check("reset_mid_op", outs(), 4'b0000);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("recover_e%0d", c), outs(), (c == 6) ? 4'b0001 : 4'b0000);
    end

    // Reset in the middle of a debounce discards the partial count.
    lever_left = 1'b0; lever_right = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lever_left = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("partial_discard_e%0d", c), outs(), (c == 6) ? 4'b1000 : 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
